// File: rtl/ws2812_frame_buffer.sv
// Double-buffered WS2812 pixel store feeding a serializer through a valid/ready handshake.
// Optional global brightness scaling is enabled by defining WS2812_BRIGHTNESS_EN.
module ws2812_frame_buffer #(
    parameter int NUM_LEDS = 16,
    parameter int ADDR_W   = 5
) (
    input  logic              i_clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [23:0]       i_wr_rgb,
    input  logic              i_swap_req,
    input  logic              i_frame_start,
    input  logic              i_px_ready,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]        i_brightness,
`endif
    output logic              o_px_valid,
    output logic [7:0]        o_red,
    output logic [7:0]        o_green,
    output logic [7:0]        o_blue,
    output logic              o_frame_end,
    output logic              o_swap_done
);

    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);
    localparam logic [ADDR_W:0]   LEDS_EXT = (ADDR_W + 1)'(NUM_LEDS);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] px_idx_q, px_idx_d;
    logic              front_sel_q, front_sel_d;
    logic              swap_pend_q, swap_pend_d;
    logic              px_valid_q, px_valid_d;
    logic              frame_end_q, frame_end_d;
    logic              swap_done_q, swap_done_d;
    logic [7:0]        red_q, red_d;
    logic [7:0]        green_q, green_d;
    logic [7:0]        blue_q, blue_d;

    logic [23:0] bank0_q [NUM_LEDS];
    logic [23:0] bank1_q [NUM_LEDS];
    logic        wr_ok;
    logic [23:0] rd_word;

`ifdef WS2812_BRIGHTNESS_EN
    logic        fetch_stage_q, fetch_stage_d;
    logic [23:0] rd_q, rd_d;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        return 8'(({8'h00, c} * ({8'h00, b} + 16'd1)) >> 8);
    endfunction
`endif

    always_comb begin
        wr_ok   = i_wr_en && ({1'b0, i_wr_addr} < LEDS_EXT);
        rd_word = front_sel_q ? bank1_q[px_idx_q[IDX_W-1:0]] : bank0_q[px_idx_q[IDX_W-1:0]];
    end

    // Bank contents are deliberately unreset so a frame survives rst_n.
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            if (front_sel_q) begin
                bank0_q[i_wr_addr[IDX_W-1:0]] <= i_wr_rgb;
            end else begin
                bank1_q[i_wr_addr[IDX_W-1:0]] <= i_wr_rgb;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        px_idx_d    = px_idx_q;
        front_sel_d = front_sel_q;
        swap_pend_d = swap_pend_q | i_swap_req;
        px_valid_d  = px_valid_q;
        frame_end_d = 1'b0;
        swap_done_d = 1'b0;
        red_d       = red_q;
        green_d     = green_q;
        blue_d      = blue_q;
`ifdef WS2812_BRIGHTNESS_EN
        fetch_stage_d = fetch_stage_q;
        rd_d          = rd_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_frame_start) begin
                    px_idx_d = '0;
                    state_d  = FETCH;
                end else if (swap_pend_q) begin
                    front_sel_d = ~front_sel_q;
                    swap_pend_d = i_swap_req;
                    swap_done_d = 1'b1;
                end
            end
            FETCH: begin
`ifdef WS2812_BRIGHTNESS_EN
                // First FETCH cycle captures the RAM word, second applies the scale.
                if (!fetch_stage_q) begin
                    rd_d          = rd_word;
                    fetch_stage_d = 1'b1;
                end else begin
                    fetch_stage_d = 1'b0;
                    red_d         = scale(rd_q[23:16], i_brightness);
                    green_d       = scale(rd_q[15:8], i_brightness);
                    blue_d        = scale(rd_q[7:0], i_brightness);
                    px_valid_d    = 1'b1;
                    state_d       = PRESENT;
                end
`else
                red_d      = rd_word[23:16];
                green_d    = rd_word[15:8];
                blue_d     = rd_word[7:0];
                px_valid_d = 1'b1;
                state_d    = PRESENT;
`endif
            end
            PRESENT: begin
                if (px_valid_q && i_px_ready) begin
                    px_valid_d = 1'b0;
                    if (px_idx_q == LAST_IDX) begin
                        frame_end_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        px_idx_d = px_idx_q + 1'b1;
                        state_d  = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            px_idx_q    <= '0;
            front_sel_q <= 1'b0;
            swap_pend_q <= 1'b0;
            px_valid_q  <= 1'b0;
            frame_end_q <= 1'b0;
            swap_done_q <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
`ifdef WS2812_BRIGHTNESS_EN
            fetch_stage_q <= 1'b0;
            rd_q          <= '0;
`endif
        end else begin
            state_q     <= state_d;
            px_idx_q    <= px_idx_d;
            front_sel_q <= front_sel_d;
            swap_pend_q <= swap_pend_d;
            px_valid_q  <= px_valid_d;
            frame_end_q <= frame_end_d;
            swap_done_q <= swap_done_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
`ifdef WS2812_BRIGHTNESS_EN
            fetch_stage_q <= fetch_stage_d;
            rd_q          <= rd_d;
`endif
        end
    end

    always_comb begin
        o_px_valid  = px_valid_q;
        o_red       = red_q;
        o_green     = green_q;
        o_blue      = blue_q;
        o_frame_end = frame_end_q;
        o_swap_done = swap_done_q;
    end

endmodule

// File: tb/tb_ws2812_frame_buffer.sv
// Directed/randomized bench for ws2812_frame_buffer against a bank-level reference model.
module tb_ws2812_frame_buffer;

    localparam int NUM_LEDS = 16;
    localparam int ADDR_W   = 5;
`ifdef WS2812_BRIGHTNESS_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              i_clk;
    logic              rst_n;
    logic              i_wr_en;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [23:0]       i_wr_rgb;
    logic              i_swap_req;
    logic              i_frame_start;
    logic              i_px_ready;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0]        i_brightness;
`endif
    logic              o_px_valid;
    logic [7:0]        o_red, o_green, o_blue;
    logic              o_frame_end;
    logic              o_swap_done;

    ws2812_frame_buffer #(
        .NUM_LEDS(NUM_LEDS),
        .ADDR_W  (ADDR_W)
    ) dut (
        .i_clk        (i_clk),
        .rst_n        (rst_n),
        .i_wr_en      (i_wr_en),
        .i_wr_addr    (i_wr_addr),
        .i_wr_rgb     (i_wr_rgb),
        .i_swap_req   (i_swap_req),
        .i_frame_start(i_frame_start),
        .i_px_ready   (i_px_ready),
`ifdef WS2812_BRIGHTNESS_EN
        .i_brightness (i_brightness),
`endif
        .o_px_valid   (o_px_valid),
        .o_red        (o_red),
        .o_green      (o_green),
        .o_blue       (o_blue),
        .o_frame_end  (o_frame_end),
        .o_swap_done  (o_swap_done)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: two banks indexed by bank number, plus which bank is displayed.
    logic [23:0] mdl [2][NUM_LEDS];
    int          mfront;

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_px(input int idx);
        logic [23:0] c;
        c = mdl[mfront][idx];
`ifdef WS2812_BRIGHTNESS_EN
        return {8'((int'(c[23:16]) * (int'(i_brightness) + 1)) / 256),
                8'((int'(c[15:8])  * (int'(i_brightness) + 1)) / 256),
                8'((int'(c[7:0])   * (int'(i_brightness) + 1)) / 256)};
`else
        return c;
`endif
    endfunction

    task automatic wr(input int addr, input logic [23:0] data);
        i_wr_en   = 1'b1;
        i_wr_addr = ADDR_W'(addr);
        i_wr_rgb  = data;
        tick();
        i_wr_en = 1'b0;
        if (addr < NUM_LEDS) mdl[1 - mfront][addr] = data;
    endtask

    task automatic do_swap();
        i_swap_req = 1'b1;
        tick();
        i_swap_req = 1'b0;
        chk("swap_not_yet", 32'(o_swap_done), 0);
        tick();
        chk("swap_done", 32'(o_swap_done), 1);
        mfront = 1 - mfront;
        tick();
        chk("swap_done_pulse", 32'(o_swap_done), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(o_px_valid), 0);
        chk({tag, "_rgb"}, 32'({o_red, o_green, o_blue}), 0);
        chk({tag, "_fend"}, 32'(o_frame_end), 0);
        chk({tag, "_sdone"}, 32'(o_swap_done), 0);
    endtask

    // swap_mode: 0 none, 1 request at pixel 3 while rewriting the back bank,
    // 2 request pending on the frame_start cycle.
    task automatic run_frame(input int stall_px, input int stall_len, input bit rnd,
                             input int swap_mode, input int abort_at);
        int idx, stall, wptr;
        bit done, was_valid, r, swapped;
        logic [23:0] d;
        idx = 0; stall = 0; wptr = 0; done = 0; swapped = 0;
        if (swap_mode == 2) begin
            i_swap_req = 1'b1;
            tick();
            i_swap_req = 1'b0;
        end
        i_frame_start = 1'b1;
        i_px_ready    = 1'b0;
        tick();
        i_frame_start = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            chk("valid_early", 32'(o_px_valid), 0);
            tick();
        end
        chk("valid_latency", 32'(o_px_valid), 1);
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            was_valid = o_px_valid;
            chk("no_frame_end", 32'(o_frame_end), 0);
            chk("no_swap_in_frame", 32'(o_swap_done), 0);
            if (was_valid) begin
                chk("pixel", 32'({o_red, o_green, o_blue}), 32'(exp_px(idx)));
                if (abort_at == idx) begin
                    rst_n = 1'b0;
                    #1;
                    chk_reset_outputs("async_reset");
                    mfront = 0;
                    i_px_ready = 1'b0;
                    tick();
                    tick();
                    chk_reset_outputs("held_reset");
                    rst_n = 1'b1;
                    tick();
                    chk_reset_outputs("after_reset");
                    return;
                end
            end
            if (was_valid && idx == stall_px && stall < stall_len) begin
                r = 1'b0;
                stall++;
            end else begin
                r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            i_px_ready = r;
            i_swap_req = 1'b0;
            i_wr_en    = 1'b0;
            if (swap_mode == 1 && idx >= 3) begin
                if (!swapped) begin
                    i_swap_req = 1'b1;
                    swapped    = 1'b1;
                end
                if (wptr < NUM_LEDS) begin
                    d         = 24'($urandom);
                    i_wr_en   = 1'b1;
                    i_wr_addr = ADDR_W'(wptr);
                    i_wr_rgb  = d;
                    mdl[1 - mfront][wptr] = d;
                    wptr++;
                end
            end
            tick();
            if (was_valid && !r) chk("hold_valid", 32'(o_px_valid), 1);
            if (was_valid && r) begin
                idx++;
                chk("valid_drop", 32'(o_px_valid), 0);
                if (idx == NUM_LEDS) begin
                    chk("frame_end", 32'(o_frame_end), 1);
                    done = 1'b1;
                end
            end
        end
        i_px_ready = 1'b0;
        i_swap_req = 1'b0;
        i_wr_en    = 1'b0;
        chk("handshakes", 32'(idx), NUM_LEDS);
        if (done) begin
            tick();
            chk("frame_end_pulse", 32'(o_frame_end), 0);
            chk("swap_after_frame", 32'(o_swap_done), 32'(swap_mode != 0));
            if (swap_mode != 0) mfront = 1 - mfront;
            tick();
            chk("swap_done_clear", 32'(o_swap_done), 0);
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        i_wr_en       = 1'b0;
        i_wr_addr     = '0;
        i_wr_rgb      = '0;
        i_swap_req    = 1'b0;
        i_frame_start = 1'b0;
        i_px_ready    = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
        i_brightness  = 8'h7F;
`endif
        mfront = 0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("post_reset");

        for (int i = 0; i < NUM_LEDS; i++) begin
            if (i == 0)      wr(i, 24'h11_22_33);
            else if (i == 1) wr(i, 24'hFF_80_02);
            else             wr(i, 24'($urandom));
        end
        do_swap();
        run_frame(-1, 0, 1'b0, 0, -1);
        run_frame(5, 50, 1'b0, 0, -1);
        run_frame(-1, 0, 1'b1, 0, -1);

        for (int i = 0; i < NUM_LEDS; i++) wr(i, 24'($urandom));
        wr(NUM_LEDS, 24'hFF_FF_FF);
        wr(31, 24'hFF_FF_FF);
        do_swap();
        run_frame(-1, 0, 1'b1, 0, -1);

        run_frame(-1, 0, 1'b1, 2, -1);
        run_frame(-1, 0, 1'b1, 1, -1);
        run_frame(-1, 0, 1'b1, 0, -1);

        do_swap();
        run_frame(-1, 0, 1'b1, 0, 8);
        run_frame(-1, 0, 1'b1, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_buffer.md
WS2812_FRAME_BUFFER -- requirements
Module: ws2812_frame_buffer

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 16, giving the number of pixels per frame (legal range 2..32).
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the pixel-index width, with 2^ADDR_W >= NUM_LEDS.
REQ-003 Port i_clk, input, 1 bit: the single clock (100 MHz); all logic is on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port i_wr_en, input, 1 bit: host pixel write strobe.
REQ-006 Port i_wr_addr, input, ADDR_W bits: host pixel index.
REQ-007 Port i_wr_rgb, input, 24 bits: host pixel colour {R[23:16], G[15:8], B[7:0]}.
REQ-008 Port i_swap_req, input, 1 bit: one-cycle pulse requesting a front/back bank swap.
REQ-009 Port i_frame_start, input, 1 bit: one-cycle pulse from the serializer at the end of its reset/latch gap.
REQ-010 Port i_px_ready, input, 1 bit: the serializer is ready to latch a pixel.
REQ-011 Port o_px_valid, output, 1 bit: pixel data is valid.
REQ-012 Ports o_red, o_green and o_blue, outputs, 8 bits each: the pixel colour presented to the serializer.
REQ-013 Port o_frame_end, output, 1 bit: one-cycle pulse after the last pixel handshake.
REQ-014 Port o_swap_done, output, 1 bit: one-cycle pulse when a bank swap takes effect.

Function
REQ-015 The block SHALL hold two banks of NUM_LEDS x 24-bit storage with synchronous read and no reset of contents; front_sel selects the bank being read.
REQ-016 Host writes with i_wr_en=1 SHALL go to the back bank (!front_sel) in the same cycle; writes with i_wr_addr >= NUM_LEDS SHALL be dropped.
REQ-017 The read FSM SHALL have states IDLE, FETCH and PRESENT.
REQ-018 In IDLE, i_frame_start SHALL clear px_idx to 0 and move the FSM to FETCH.
REQ-019 In FETCH, the block SHALL issue a RAM read of px_idx and move to PRESENT on the next cycle.
REQ-020 On entering PRESENT, o_px_valid SHALL be 1 with the registered data, so o_px_valid rises 2 cycles after i_frame_start.
REQ-021 Data and o_px_valid SHALL stay stable while i_px_ready=0.
REQ-022 A handshake SHALL occur when o_px_valid=1 and i_px_ready=1.
REQ-023 On a handshake with px_idx < NUM_LEDS-1, the block SHALL clear o_px_valid, increment px_idx and move to FETCH.
REQ-024 On a handshake with px_idx = NUM_LEDS-1, the block SHALL clear o_px_valid, pulse o_frame_end and return to IDLE.
REQ-025 i_frame_start received outside IDLE SHALL be ignored.
REQ-026 i_swap_req SHALL set a sticky swap_pend flag.
REQ-027 When swap_pend=1 and the FSM is in IDLE and not receiving i_frame_start, the block SHALL toggle front_sel, clear swap_pend and pulse o_swap_done in the same cycle; a frame in flight is never torn.
REQ-028 If i_frame_start coincides with a pending swap in IDLE, the frame start SHALL take priority and the swap SHALL occur after o_frame_end.
REQ-029 A write in the same cycle as a swap SHALL target the pre-swap back bank.
REQ-030 px_idx SHALL never wrap; the index saturates at NUM_LEDS-1 by construction.

Reset
REQ-031 While rst_n=0, the block SHALL asynchronously force: FSM to IDLE; px_idx, front_sel and swap_pend to 0; o_px_valid, o_frame_end and o_swap_done to 0; o_red, o_green and o_blue to 8'h00.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no o_frame_end pulse.
REQ-033 Bank contents SHALL be preserved through reset.

Configuration
REQ-034 With macro WS2812_BRIGHTNESS_EN defined, the block SHALL add input port i_brightness (8 bits).
REQ-035 With WS2812_BRIGHTNESS_EN defined, each output colour SHALL be (c*(i_brightness+1))>>8, computed in 16 bits, truncated, and registered in one extra pipeline stage, so o_px_valid rises 3 cycles after i_frame_start.
REQ-036 Without WS2812_BRIGHTNESS_EN, port i_brightness SHALL be absent and colours SHALL pass through unscaled with 2-cycle latency.

Verification
REQ-037 Write index 0 = 24'h11_22_33, swap, then frame_start with i_px_ready held 1 -> o_swap_done pulses; o_red=8'h11, o_green=8'h22 and o_blue=8'h33 with valid at cycle +2; 16 handshakes occur, then o_frame_end.
REQ-038 Hold i_px_ready=0 for 50 cycles during pixel 5 -> o_px_valid and the data stay constant; exactly 16 handshakes occur in total.
REQ-039 Pulse i_swap_req at pixel 3 while the host rewrites all pixels -> the current frame shows the old data; o_swap_done pulses 1 cycle after o_frame_end; the next frame shows the new data.
REQ-040 Pulse rst_n low at pixel 8 -> all outputs go to 0 immediately with no o_frame_end; after release, the next frame_start replays the preserved bank from pixel 0.
REQ-041 Write to i_wr_addr=NUM_LEDS with 24'hFFFFFF -> no pixel changes.
REQ-042 With WS2812_BRIGHTNESS_EN defined, i_brightness=8'h7F and pixel 24'hFF_80_02 -> outputs 8'h7F, 8'h40 and 8'h01, with valid at cycle +3.
